// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - program counter generator with BOOT/RUN/TRAP sequencing and MEPC save/restore.
// Optional macro PC_MISALIGN_TRAP_EN turns misaligned RUN redirects into traps.
module pc_gen #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'('h100)
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            Stall,
  input  logic            Trap,
  input  logic [1:0]      PCSrc,
  input  logic [XLEN-1:0] PCTarget,
  input  logic [XLEN-1:0] ALUResult,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  output logic [XLEN-1:0] MEPC,
  output logic            Valid,
  output logic            InTrap,
  output logic            Misalign
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_TRAP} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] next_tgt;
  logic            is_redirect;

  // JALR drops bit 0 of the ALU result, so that bit never reaches the PC.
  logic unused_alu_bit;
  assign unused_alu_bit = ALUResult[0];

  assign PCPlus4 = pc_q + XLEN'(4);

  always_comb begin
    next_tgt    = PCPlus4;
    is_redirect = 1'b0;
    case (PCSrc)
      2'b01: begin
        next_tgt    = PCTarget;
        is_redirect = 1'b1;
      end
      2'b10: begin
        next_tgt    = {ALUResult[XLEN-1:1], 1'b0};
        is_redirect = 1'b1;
      end
      default: next_tgt = PCPlus4;
    endcase
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic mis_q, mis_d;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mepc_d  = mepc_q;
`ifdef PC_MISALIGN_TRAP_EN
    mis_d   = 1'b0;
`endif
    case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        if (Trap) begin
          mepc_d  = pc_q;
          pc_d    = TRAP_VEC;
          state_d = S_TRAP;
        end else if (!Stall) begin
`ifdef PC_MISALIGN_TRAP_EN
          if (is_redirect && (next_tgt[1:0] != 2'b00)) begin
            mepc_d  = pc_q;
            pc_d    = TRAP_VEC;
            state_d = S_TRAP;
            mis_d   = 1'b1;
          end else begin
            pc_d = next_tgt;
          end
`else
          pc_d = next_tgt;
`endif
        end
      end
      S_TRAP: begin
        // Trap is deliberately ignored here: handlers do not nest.
        if (!Stall) begin
          if (PCSrc == 2'b11) begin
            pc_d    = mepc_q;
            state_d = S_RUN;
          end else begin
`ifdef PC_MISALIGN_TRAP_EN
            pc_d = is_redirect ? {next_tgt[XLEN-1:2], 2'b00} : next_tgt;
`else
            pc_d = next_tgt;
`endif
          end
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_VEC;
      mepc_q  <= '0;
`ifdef PC_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mepc_q  <= mepc_d;
`ifdef PC_MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign PC     = pc_q;
  assign MEPC   = mepc_q;
  assign Valid  = (state_q != S_BOOT);
  assign InTrap = (state_q == S_TRAP);
`ifdef PC_MISALIGN_TRAP_EN
  assign Misalign = mis_q;
`else
  assign Misalign = 1'b0;
`endif

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC and address width.
REQ-002 SHALL have parameter RESET_VEC, default 32'h0000_0000, PC value after reset.
REQ-003 SHALL have parameter TRAP_VEC, default 32'h0000_0100, trap handler entry address.
REQ-004 SHALL have port CLK  in  1  rising-edge clock; the block has one clock.
REQ-005 SHALL have port Reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port Stall  in  1  hold the PC and the state this cycle.
REQ-007 SHALL have port Trap  in  1  exception request.
REQ-008 SHALL have port PCSrc  in  2  next-PC select: 00 PC+4, 01 PCTarget, 10 ALUResult, 11 return to MEPC.
REQ-009 SHALL have port PCTarget  in  XLEN  branch or JAL target.
REQ-010 SHALL have port ALUResult  in  XLEN  JALR target.
REQ-011 SHALL have port PC  out  XLEN  current fetch address, registered.
REQ-012 SHALL have port PCPlus4  out  XLEN  combinational PC+4, modulo 2^XLEN.
REQ-013 SHALL have port MEPC  out  XLEN  saved trap return address, registered.
REQ-014 SHALL have port Valid  out  1  PC is a valid fetch address.
REQ-015 SHALL have port InTrap  out  1  high while in state TRAP.
REQ-016 SHALL have port Misalign  out  1  one-cycle pulse on a misaligned-redirect trap.

Function
REQ-017 SHALL implement an FSM with states BOOT, RUN and TRAP, updated only on the rising edge of CLK.
REQ-018 SHALL move BOOT to RUN unconditionally after one cycle, with PC=RESET_VEC and Valid=0 while in BOOT.
REQ-019 SHALL, in RUN and TRAP, keep Valid=1 and apply one-cycle latency: a select sampled on edge N is seen on PC after edge N.
REQ-020 SHALL apply priority Trap > Stall > PCSrc in RUN.
REQ-021 SHALL, on a RUN Trap: MEPC<=PC, PC<=TRAP_VEC, state<=TRAP.
REQ-022 SHALL, on a RUN Stall with no Trap, hold PC, MEPC and state.
REQ-023 SHALL, in RUN: PCSrc=00 gives PC<=PC+4 (wraps 32'hFFFF_FFFC to 0); 01 gives PCTarget; 10 gives {ALUResult[XLEN-1:1],1'b0}; 11 is treated as 00.
REQ-024 SHALL ignore Trap in TRAP (no nesting) and leave MEPC unchanged.
REQ-025 SHALL, in TRAP, honour Stall and PCSrc 00/01/10 as in RUN, and on PCSrc=11 set PC<=MEPC, state<=RUN, InTrap<=0.
REQ-026 SHALL have PCPlus4 follow PC in the same cycle, including while stalled.

Reset
REQ-027 SHALL, when Reset=1 at a rising edge, set PC=RESET_VEC, MEPC=0, state=BOOT, Valid=0, InTrap=0, Misalign=0, overriding Trap, Stall and PCSrc.
REQ-028 SHALL abandon TRAP on a mid-trap reset, leaving MEPC=0.
REQ-029 SHALL hold the reset values for as long as Reset stays high; BOOT lasts one cycle after Reset falls.

Configuration
REQ-030 SHALL, with macro PC_MISALIGN_TRAP_EN defined, treat a RUN redirect (01, or 10 after bit 0 clear) with target[1:0]!=0 and no Stall as a trap: MEPC<=PC, PC<=TRAP_VEC, state<=TRAP, Misalign=1 for one cycle.
REQ-031 SHALL, with PC_MISALIGN_TRAP_EN defined, in TRAP load a misaligned target with bits [1:0] cleared and no trap.
REQ-032 SHALL, without PC_MISALIGN_TRAP_EN, load targets unchecked (only REQ-023 bit-0 clear) and tie Misalign to 0.

Verification
REQ-033 SHALL cover: Reset high 2 cycles then low -> PC=0, Valid=0 for one cycle, then Valid=1 and PC 0,4,8 under PCSrc=00.
REQ-034 SHALL cover: at PC=8, PCSrc=01, PCTarget=32'h100 -> PC=32'h100; then PCSrc=10, ALUResult=32'h011 -> PC=32'h010.
REQ-035 SHALL cover: at PC=32'h010, Stall=1 for 3 cycles with PCSrc=01 -> PC stays 32'h010 and PCPlus4=32'h014.
REQ-036 SHALL cover: at PC=32'h040 with Trap=1 -> PC=32'h100, MEPC=32'h040, InTrap=1; a second Trap is ignored; PCSrc=11 -> PC=32'h040, InTrap=0.
REQ-037 SHALL cover: PC=32'hFFFF_FFFC with PCSrc=00 -> PC=0; Reset asserted in TRAP -> PC=0, MEPC=0, InTrap=0.
REQ-038 SHALL cover, with PC_MISALIGN_TRAP_EN, at PC=32'h020 with PCSrc=01, PCTarget=32'h102 -> Misalign=1, PC=32'h100, MEPC=32'h020; without the macro -> PC=32'h102.
